dsp_simd_mac: RTL and testbench

- Parametrised SIMD multiply-accumulate slice. It is the next-generation DSP slice for the PIR-DSP model.
- Splits the datapath into LANES independent lanes. Each lane has a signed/unsigned multiplier, an ALU stage and an accumulator.
- Accumulator cascade runs via PCIN/PCOUT.
- Adds a valid/ready streaming handshake, a configurable multiplier pipeline depth and per-lane overflow flags.
- Sits between the operand buffers and the cascade chain, in place of single-lane slices.

---
 rtl/dsp_simd_pkg.sv | 22 ++
 rtl/dsp_simd_lane.sv | 129 ++++++++++++
 rtl/dsp_simd_mac.sv | 91 +++++++++
 tb/tb_dsp_simd_mac.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dsp_simd_pkg.sv
// Shared definitions for the SIMD multiply-accumulate slice: ALU opcodes and
// lane-packing helpers used by dsp_simd_mac and dsp_simd_lane.
package dsp_simd_pkg;

  localparam int OPMODE_W = 3;

  typedef enum logic [OPMODE_W-1:0] {
    OP_MUL     = 3'b000,
    OP_ACC     = 3'b001,
    OP_SUB     = 3'b010,
    OP_CADD    = 3'b011,
    OP_CASC    = 3'b100,
    OP_CASCACC = 3'b101,
    OP_HOLD    = 3'b110
  } op_e;

  // LSB position of a lane inside a lane-packed bus, lane 0 in the LSBs.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/dsp_simd_lane.sv
// One SIMD lane: signed/unsigned multiplier, M_STAGES operand/product registers,
// ALU and P register with overflow detection. Saturation under DSP_SIMD_SATURATE_EN.
module dsp_simd_lane
  import dsp_simd_pkg::*;
#(
  parameter int A_W      = 8,
  parameter int B_W      = 8,
  parameter int ACC_W    = 24,
  parameter int M_STAGES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                adv,
  input  logic                p_en,
  input  logic [A_W-1:0]      a,
  input  logic [B_W-1:0]      b,
  input  logic [ACC_W-1:0]    c,
  input  logic [ACC_W-1:0]    pcin,
  input  logic [OPMODE_W-1:0] op,
  input  logic                sgn,
  output logic [ACC_W-1:0]    p,
  output logic                ovf
);

  localparam int PW = A_W + B_W + 1;

  typedef struct packed {
    logic [ACC_W-1:0]    m;
    logic [ACC_W-1:0]    c;
    logic [ACC_W-1:0]    pcin;
    logic [OPMODE_W-1:0] op;
    logic                sgn;
  } stage_t;

  logic signed [A_W:0]     a_ext;
  logic signed [B_W:0]     b_ext;
  logic signed [PW-1:0]    a_w;
  logic signed [PW-1:0]    b_w;
  logic signed [PW-1:0]    prod;
  logic        [ACC_W-1:0] m_ext;
  stage_t                  in_s;
  stage_t                  alu_s;

  // One extra operand bit selects sign or zero extension; the product always fits PW signed bits.
  assign a_ext = {sgn & a[A_W-1], a};
  assign b_ext = {sgn & b[B_W-1], b};
  assign a_w   = PW'(a_ext);
  assign b_w   = PW'(b_ext);
  assign prod  = a_w * b_w;
  assign m_ext = ACC_W'(prod);
  assign in_s  = '{m: m_ext, c: c, pcin: pcin, op: op, sgn: sgn};

  generate
    if (M_STAGES == 0) begin : g_no_mreg
      assign alu_s = in_s;
    end else begin : g_mreg
      stage_t pipe [M_STAGES];

      // NOTE: the staged-operand registers are reset too, so a cleared slice carries no stale beat data.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < M_STAGES; i++) pipe[i] <= '0;
        end else if (adv) begin
          pipe[0] <= in_s;
          for (int i = 1; i < M_STAGES; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign alu_s = pipe[M_STAGES-1];
    end
  endgenerate

  logic [ACC_W-1:0] x;
  logic [ACC_W-1:0] y;
  logic             sub;
  logic             hold;
  logic [ACC_W:0]   wide;
  logic [ACC_W-1:0] res;
  logic             s_ovf;
  logic             ovf_next;
  logic [ACC_W-1:0] p_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    x    = '0;
    y    = alu_s.m;
    sub  = 1'b0;
    hold = 1'b0;
    case (alu_s.op)
      OP_MUL:     x = '0;
      OP_ACC:     x = p;
      OP_SUB:     begin x = p; sub = 1'b1; end
      OP_CADD:    x = alu_s.c;
      OP_CASC:    x = alu_s.pcin;
      OP_CASCACC: begin x = alu_s.pcin; y = p; end
      default:    hold = 1'b1;
    endcase

    wide  = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    res   = wide[ACC_W-1:0];
    // Signed overflow: result sign disagrees with x when the effective operands share a sign.
    s_ovf = (sub ? (x[ACC_W-1] != y[ACC_W-1]) : (x[ACC_W-1] == y[ACC_W-1]))
            && (res[ACC_W-1] != x[ACC_W-1]);
    ovf_next = alu_s.sgn ? s_ovf : wide[ACC_W];

`ifdef DSP_SIMD_SATURATE_EN
    if (!ovf_next)
      p_next = res;
    else if (alu_s.sgn)
      p_next = x[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      p_next = sub ? '0 : '1;
`else
    p_next = res;
`endif
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p   <= '0;
      ovf <= 1'b0;
    end else if (p_en && !hold) begin
      p   <= p_next;
      ovf <= ovf_next;
    end
  end

endmodule

// File: rtl/dsp_simd_mac.sv
// SIMD multiply-accumulate slice top: valid pipeline, valid/ready handshake and
// LANES dsp_simd_lane instances. Optional clamping via DSP_SIMD_SATURATE_EN.
module dsp_simd_mac
  import dsp_simd_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int A_W      = 8,
  parameter int B_W      = 8,
  parameter int ACC_W    = 24,
  parameter int M_STAGES = 1
) (
  input  logic                   clk,
  input  logic                   RST_N,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*A_W-1:0]   A,
  input  logic [LANES*B_W-1:0]   B,
  input  logic [LANES*ACC_W-1:0] C,
  input  logic [LANES*ACC_W-1:0] PCIN,
  input  logic [OPMODE_W-1:0]    OPMODE,
  input  logic                   SIGNED,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ACC_W-1:0] P,
  output logic [LANES*ACC_W-1:0] PCOUT,
  output logic [LANES-1:0]       OVERFLOW
);

  logic adv;
  logic p_valid;
  logic p_en;

  // The whole pipeline stalls as a unit while an unconsumed result sits in P.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  generate
    if (M_STAGES == 0) begin : g_no_vpipe
      assign p_valid = in_valid;
    end else begin : g_vpipe
      logic [M_STAGES-1:0] v_pipe;

      always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
          v_pipe <= '0;
        end else if (adv) begin
          v_pipe[0] <= in_valid;
          for (int i = 1; i < M_STAGES; i++) v_pipe[i] <= v_pipe[i-1];
        end
      end

      assign p_valid = v_pipe[M_STAGES-1];
    end
  endgenerate

  assign p_en = adv && p_valid;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N)   out_valid <= 1'b0;
    else if (adv) out_valid <= p_valid;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int AL = lane_lsb(i, A_W);
    localparam int BL = lane_lsb(i, B_W);
    localparam int PL = lane_lsb(i, ACC_W);

    dsp_simd_lane #(
      .A_W      (A_W),
      .B_W      (B_W),
      .ACC_W    (ACC_W),
      .M_STAGES (M_STAGES)
    ) u_lane (
      .clk   (clk),
      .rst_n (RST_N),
      .adv   (adv),
      .p_en  (p_en),
      .a     (A[AL +: A_W]),
      .b     (B[BL +: B_W]),
      .c     (C[PL +: ACC_W]),
      .pcin  (PCIN[PL +: ACC_W]),
      .op    (OPMODE),
      .sgn   (SIGNED),
      .p     (P[PL +: ACC_W]),
      .ovf   (OVERFLOW[i])
    );
  end

  assign PCOUT = P;

endmodule

// File: tb/tb_dsp_simd_mac.sv
// Self-checking bench for dsp_simd_mac (LANES=4, 8x8 operands, ACC_W=24, M_STAGES=1):
// a table of single-beat vectors plus hand-written multi-cycle sequences.
module tb_dsp_simd_mac;
  import dsp_simd_pkg::*;

  localparam int LANES = 4;
  localparam int A_W   = 8;
  localparam int B_W   = 8;
  localparam int ACC_W = 24;

  logic                   clk = 1'b0;
  logic                   RST_N;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*A_W-1:0]   A;
  logic [LANES*B_W-1:0]   B;
  logic [LANES*ACC_W-1:0] C;
  logic [LANES*ACC_W-1:0] PCIN;
  logic [2:0]             OPMODE;
  logic                   SIGNED;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*ACC_W-1:0] P;
  logic [LANES*ACC_W-1:0] PCOUT;
  logic [LANES-1:0]       OVERFLOW;

  dsp_simd_mac #(
    .LANES(LANES), .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .M_STAGES(1)
  ) dut (
    .clk(clk), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C(C), .PCIN(PCIN), .OPMODE(OPMODE), .SIGNED(SIGNED),
    .out_valid(out_valid), .out_ready(out_ready), .P(P), .PCOUT(PCOUT),
    .OVERFLOW(OVERFLOW)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]             op;
    logic                   sgn;
    logic [LANES*A_W-1:0]   a;
    logic [LANES*B_W-1:0]   b;
    logic [LANES*ACC_W-1:0] c;
    logic [LANES*ACC_W-1:0] pcin;
    logic [LANES*ACC_W-1:0] exp_p;
    logic [LANES-1:0]       exp_ovf;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] pack8(input int l0, input int l1, input int l2, input int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  function automatic logic [95:0] pack24(input int l0, input int l1, input int l2, input int l3);
    return {24'(l3), 24'(l2), 24'(l1), 24'(l0)};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [95:0] c, input logic [95:0] pcin);
    OPMODE = op; SIGNED = sgn; A = a; B = b; C = c; PCIN = pcin;
    in_valid = 1'b1;
  endtask

  // Present one beat with out_ready=1 and wait (bounded) for its result; called at a negedge.
  task automatic do_beat(input string name, input vec_t v);
    int n;
    out_ready = 1'b1;
    drive(v.op, v.sgn, v.a, v.b, v.c, v.pcin);
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    check({name, "_out_valid"}, 96'(out_valid), 96'(1));
  endtask

  vec_t vecs [12];
  vec_t v;

  initial begin
    vecs[0]  = '{op: OP_MUL, sgn: 1'b1, a: pack8(-3, 5, 127, -128), b: pack8(4, -6, 127, -128),
                 c: '0, pcin: '0, exp_p: pack24(-12, -30, 16129, 16384), exp_ovf: 4'h0};
    vecs[1]  = '{op: OP_ACC, sgn: 1'b1, a: pack8(1, 1, 1, 1), b: pack8(2, -2, 0, -1),
                 c: '0, pcin: '0, exp_p: pack24(-10, -32, 16129, 16383), exp_ovf: 4'h0};
    vecs[2]  = '{op: OP_SUB, sgn: 1'b1, a: pack8(1, 1, 1, 1), b: pack8(3, 3, 3, 3),
                 c: '0, pcin: '0, exp_p: pack24(-13, -35, 16126, 16380), exp_ovf: 4'h0};
    vecs[3]  = '{op: OP_CADD, sgn: 1'b0, a: pack8(2, 2, 2, 2), b: pack8(3, 3, 3, 3),
                 c: pack24(1000, 2000, 0, 5), pcin: '0, exp_p: pack24(1006, 2006, 6, 11), exp_ovf: 4'h0};
    vecs[4]  = '{op: OP_CASC, sgn: 1'b0, a: pack8(1, 1, 1, 1), b: pack8(1, 1, 1, 1),
                 c: '0, pcin: pack24(100, 200, 300, 400), exp_p: pack24(101, 201, 301, 401), exp_ovf: 4'h0};
    vecs[5]  = '{op: OP_CASCACC, sgn: 1'b0, a: pack8(0, 0, 0, 0), b: pack8(0, 0, 0, 0),
                 c: '0, pcin: pack24(1, 2, 3, 4), exp_p: pack24(102, 203, 304, 405), exp_ovf: 4'h0};
    vecs[6]  = '{op: 3'b110, sgn: 1'b0, a: pack8(9, 9, 9, 9), b: pack8(9, 9, 9, 9),
                 c: pack24(7, 7, 7, 7), pcin: pack24(7, 7, 7, 7), exp_p: pack24(102, 203, 304, 405), exp_ovf: 4'h0};
    vecs[7]  = '{op: 3'b111, sgn: 1'b1, a: pack8(9, 9, 9, 9), b: pack8(9, 9, 9, 9),
                 c: pack24(7, 7, 7, 7), pcin: pack24(7, 7, 7, 7), exp_p: pack24(102, 203, 304, 405), exp_ovf: 4'h0};
    vecs[8]  = '{op: OP_CADD, sgn: 1'b0, a: pack8(1, 1, 1, 1), b: pack8(1, 1, 1, 1),
                 c: pack24(-1, -1, -1, -1), pcin: '0, exp_p: pack24(0, 0, 0, 0), exp_ovf: 4'hF};
    vecs[9]  = '{op: OP_SUB, sgn: 1'b0, a: pack8(1, 1, 1, 1), b: pack8(5, 5, 5, 5),
                 c: '0, pcin: '0, exp_p: pack24(-5, -5, -5, -5), exp_ovf: 4'hF};
    vecs[10] = '{op: OP_MUL, sgn: 1'b0, a: pack8(255, 255, 255, 255), b: pack8(255, 255, 255, 255),
                 c: '0, pcin: '0, exp_p: pack24(65025, 65025, 65025, 65025), exp_ovf: 4'h0};
    vecs[11] = '{op: OP_MUL, sgn: 1'b1, a: pack8(-1, -1, 2, -7), b: pack8(-1, 3, -4, -7),
                 c: '0, pcin: '0, exp_p: pack24(1, -3, -8, 49), exp_ovf: 4'h0};

    RST_N = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; C = '0; PCIN = '0; OPMODE = '0; SIGNED = 1'b0;
    #1;
    check("reset_P", P, '0);
    check("reset_OVERFLOW", 96'(OVERFLOW), '0);
    check("reset_out_valid", 96'(out_valid), '0);
    check("reset_in_ready", 96'(in_ready), 96'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    RST_N = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_beat($sformatf("vec%0d", i), vecs[i]);
      check($sformatf("vec%0d_P", i), P, vecs[i].exp_p);
      check($sformatf("vec%0d_PCOUT", i), PCOUT, vecs[i].exp_p);
      check($sformatf("vec%0d_OVERFLOW", i), 96'(OVERFLOW), 96'(vecs[i].exp_ovf));
    end

    // Back-to-back unsigned accumulate, one result per cycle, latency 2.
    @(negedge clk);
    out_ready = 1'b1;
    drive(OP_MUL, 1'b0, pack8(255, 255, 255, 255), pack8(255, 255, 255, 255), '0, '0);
    @(posedge clk); @(negedge clk);
    check("b2b_latency_out_valid", 96'(out_valid), '0);
    OPMODE = OP_ACC;
    @(posedge clk); @(negedge clk);
    check("b2b_P1", P, pack24(65025, 65025, 65025, 65025));
    @(posedge clk); @(negedge clk);
    check("b2b_P2", P, pack24(130050, 130050, 130050, 130050));
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("b2b_P3", P, pack24(195075, 195075, 195075, 195075));
    check("b2b_out_valid", 96'(out_valid), 96'(1));

    // Signed accumulate overflow: 0x7FFFF0 + 0x20 wraps to 0x800010.
    @(negedge clk);
    v = '{op: OP_CADD, sgn: 1'b1, a: '0, b: '0, c: pack24('h7FFFF0, 'h7FFFF0, 'h7FFFF0, 'h7FFFF0),
          pcin: '0, exp_p: '0, exp_ovf: '0};
    do_beat("ovf_load", v);
    check("ovf_load_P", P, pack24('h7FFFF0, 'h7FFFF0, 'h7FFFF0, 'h7FFFF0));
    v = '{op: OP_ACC, sgn: 1'b1, a: pack8(4, 4, 4, 4), b: pack8(8, 8, 8, 8), c: '0,
          pcin: '0, exp_p: '0, exp_ovf: '0};
    do_beat("ovf_acc", v);
    check("ovf_acc_P", P, pack24('h800010, 'h800010, 'h800010, 'h800010));
    check("ovf_acc_OVERFLOW", 96'(OVERFLOW), 96'(4'hF));

    // Backpressure: a stalled P must hold, and the queued beats land exactly once.
    @(negedge clk); @(negedge clk);
    out_ready = 1'b0;
    drive(OP_MUL, 1'b0, pack8(2, 2, 2, 2), pack8(3, 3, 3, 3), '0, '0);
    @(posedge clk); @(negedge clk);
    drive(OP_ACC, 1'b0, pack8(1, 1, 1, 1), pack8(1, 1, 1, 1), '0, '0);
    @(posedge clk); @(negedge clk);
    drive(OP_ACC, 1'b0, pack8(1, 1, 1, 1), pack8(2, 2, 2, 2), '0, '0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_stall%0d_in_ready", k), 96'(in_ready), '0);
      check($sformatf("bp_stall%0d_P", k), P, pack24(6, 6, 6, 6));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("bp_release_P", P, pack24(7, 7, 7, 7));
    check("bp_release_out_valid", 96'(out_valid), 96'(1));
    @(posedge clk); @(negedge clk);
    check("bp_last_P", P, pack24(9, 9, 9, 9));
    @(posedge clk); @(negedge clk);
    check("bp_drain_out_valid", 96'(out_valid), '0);
    check("bp_drain_P", P, pack24(9, 9, 9, 9));

    // Asynchronous reset with two beats in flight.
    drive(OP_MUL, 1'b0, pack8(2, 2, 2, 2), pack8(2, 2, 2, 2), '0, '0);
    @(posedge clk); @(negedge clk);
    OPMODE = OP_ACC;
    @(posedge clk);
    #2;
    RST_N = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_mid_out_valid", 96'(out_valid), '0);
    check("rst_mid_P", P, '0);
    check("rst_mid_OVERFLOW", 96'(OVERFLOW), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    RST_N = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rst_post%0d_out_valid", k), 96'(out_valid), '0);
    end
    check("rst_post_P", P, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
